// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. Produces hsync,
//                vsync and data-enable, active-area pixel coordinates for the
//                draw logic, and blank-gated RGB output. A ce-qualified delay
//                line on the sync/enable path compensates draw latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 1440,
  parameter int H_FP     = 80,
  parameter int H_SYNC   = 152,
  parameter int H_BP     = 232,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_LAT = 0,
  parameter int CW       = 4,
  parameter int XW       = 11,
  parameter int YW       = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [3*CW-1:0] draw_rgb,
  output logic [XW-1:0]   curr_x,
  output logic [YW-1:0]   curr_y,
  output logic            coord_valid,
  output logic            line_start,
  output logic            frame_start,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [3*CW-1:0] pix_rgb
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // One extra count of headroom so the active-end boundary always fits,
  // even with a zero-length front porch.
  localparam int HCW     = $clog2(H_TOTAL + 1);
  localparam int VCW     = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] c_h_last    = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] c_v_last    = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] c_h_sync    = HCW'(H_SYNC);
  localparam logic [VCW-1:0] c_v_sync    = VCW'(V_SYNC);
  localparam logic [HCW-1:0] c_h_act_beg = HCW'(H_SYNC + H_BP);
  localparam logic [HCW-1:0] c_h_act_end = HCW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VCW-1:0] c_v_act_beg = VCW'(V_SYNC + V_BP);
  localparam logic [VCW-1:0] c_v_act_end = VCW'(V_SYNC + V_BP + V_ACTIVE);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if ((PIPE_LAT < 0) || (PIPE_LAT > 7)) begin : g_chk_lat
    $error("vga_timing_gen: PIPE_LAT must be in 0..7");
  end
  if (H_ACTIVE > (1 << XW)) begin : g_chk_xw
    $error("vga_timing_gen: H_ACTIVE does not fit in XW bits");
  end
  if (V_ACTIVE > (1 << YW)) begin : g_chk_yw
    $error("vga_timing_gen: V_ACTIVE does not fit in YW bits");
  end

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;

  // Next raster position: vertical advances only when the line wraps.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (hcount_q == c_h_last) begin
      hcount_d = '0;
      if (vcount_q == c_v_last) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 1'b1;
      end
    end else begin
      hcount_d = hcount_q + 1'b1;
    end
  end

  // Counter registers: reset restarts at the frame origin, ce gates advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (ce) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: undelayed decode from the counters
  // --------------------------------------------------------------------------
  logic w_h_act;
  logic w_v_act;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_de_raw;

  // Active-window decode, coordinates and line/frame pulses.
  always_comb begin
    w_h_act     = (hcount_q >= c_h_act_beg) && (hcount_q < c_h_act_end);
    w_v_act     = (vcount_q >= c_v_act_beg) && (vcount_q < c_v_act_end);
    coord_valid = w_h_act & w_v_act;
    // Inside the window the offset is below H_ACTIVE/V_ACTIVE, so the
    // resize to XW/YW never drops significant bits.
    curr_x      = w_h_act ? XW'(hcount_q - c_h_act_beg) : '0;
    curr_y      = w_v_act ? YW'(vcount_q - c_v_act_beg) : '0;
    w_hs_raw    = (hcount_q < c_h_sync);
    w_vs_raw    = (vcount_q < c_v_sync);
    w_de_raw    = coord_valid;
    line_start  = ce && (hcount_q == '0);
    frame_start = ce && (hcount_q == '0) && (vcount_q == '0);
  end

  // --------------------------------------------------------------------------
  // Sync / enable delay line (active-sense bits; 0 means inactive)
  // --------------------------------------------------------------------------
  logic [2:0] w_raw;
  logic [2:0] w_dly;

  assign w_raw = {w_hs_raw, w_vs_raw, w_de_raw};

  if (PIPE_LAT == 0) begin : g_direct
    assign w_dly = w_raw;
  end else begin : g_pipe
    logic [2:0] dly_q [PIPE_LAT];

    // Shift register advancing on ce; reset clears every stage to inactive.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
          dly_q[i] <= '0;
        end
      end else if (ce) begin
        dly_q[0] <= w_raw;
        for (int i = 1; i < PIPE_LAT; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign w_dly = dly_q[PIPE_LAT-1];
  end

  // --------------------------------------------------------------------------
  // Output polarity and blanking
  // --------------------------------------------------------------------------
  // Apply sync polarity and force RGB to zero outside the data-enable window.
  always_comb begin
    hsync   = HS_POL ? w_dly[2] : ~w_dly[2];
    vsync   = VS_POL ? w_dly[1] : ~w_dly[1];
    de      = w_dly[0];
    pix_rgb = w_dly[0] ? draw_rgb : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen. Two instances with small
//                timing (one delayed, one direct) share randomized ce, reset
//                and draw_rgb; a frame-position model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int LAT  = 3;
  localparam int CW = 4, XW = 5, YW = 4;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            ce;
  logic [3*CW-1:0] draw_rgb;

  logic [XW-1:0]   x_a, x_b;
  logic [YW-1:0]   y_a, y_b;
  logic            cv_a, cv_b, ls_a, ls_b, fs_a, fs_b;
  logic            hs_a, hs_b, vs_a, vs_b, de_a, de_b;
  logic [3*CW-1:0] rgb_a, rgb_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL), .PIPE_LAT(LAT), .CW(CW), .XW(XW), .YW(YW)
  ) u_dut_lat (
    .clk(clk), .rst(rst), .ce(ce), .draw_rgb(draw_rgb),
    .curr_x(x_a), .curr_y(y_a), .coord_valid(cv_a),
    .line_start(ls_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .pix_rgb(rgb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(HPOL), .VS_POL(VPOL), .PIPE_LAT(0), .CW(CW), .XW(XW), .YW(YW)
  ) u_dut_dir (
    .clk(clk), .rst(rst), .ce(ce), .draw_rgb(draw_rgb),
    .curr_x(x_b), .curr_y(y_b), .coord_valid(cv_b),
    .line_start(ls_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .pix_rgb(rgb_b)
  );

  typedef struct {
    int              x;
    int              y;
    bit              cv, ls, fs;
    bit              hs_a, vs_a, de_a;
    bit              hs_b, vs_b, de_b;
    logic [3*CW-1:0] rgb_a, rgb_b;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       errors = 0;

  // Reference model: position within the frame plus a history of the
  // active-sense {hsync, vsync, de} triples seen on previous ce ticks.
  int       pos;
  bit [2:0] hist[$];

  function automatic bit [2:0] raw_at(int p);
    int  h = p % HT;
    int  v = p / HT;
    bit  ha = (h >= HS + HBP) && (h < HS + HBP + HA);
    bit  va = (v >= VS + VBP) && (v < VS + VBP + VA);
    return {bit'(h < HS), bit'(v < VS), bit'(ha && va)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one set of inputs and push the response the model predicts for it.
  task automatic issue(input bit r, input bit c);
    exp_t     e;
    bit [2:0] ra, rd;
    int       h, v;
    rst      = r;
    ce       = c;
    draw_rgb = 12'($urandom);
    h  = pos % HT;
    v  = pos / HT;
    ra = raw_at(pos);
    rd = hist[LAT-1];
    e.cv = ra[0];
    e.x  = ((h >= HS + HBP) && (h < HS + HBP + HA)) ? h - (HS + HBP) : 0;
    e.y  = ((v >= VS + VBP) && (v < VS + VBP + VA)) ? v - (VS + VBP) : 0;
    e.ls = c && (h == 0);
    e.fs = c && (h == 0) && (v == 0);
    e.hs_a = HPOL ? rd[2] : !rd[2];
    e.vs_a = VPOL ? rd[1] : !rd[1];
    e.de_a = rd[0];
    e.rgb_a = rd[0] ? draw_rgb : '0;
    e.hs_b = HPOL ? ra[2] : !ra[2];
    e.vs_b = VPOL ? ra[1] : !ra[1];
    e.de_b = ra[0];
    e.rgb_b = ra[0] ? draw_rgb : '0;
    sb.push_back(e);
  endtask

  // Stimulus: model advances at each edge using the inputs the DUT saw.
  initial begin
    rst      = 1'b0;
    ce       = 1'b0;
    draw_rgb = '0;
    pos      = 0;
    hist     = '{3'b0, 3'b0, 3'b0};
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      if (!rst) begin
        pos  = 0;
        hist = '{3'b0, 3'b0, 3'b0};
      end else if (ce) begin
        hist.push_front(raw_at(pos));
        void'(hist.pop_back());
        pos = (pos + 1) % FRAME;
      end
      #1;
      if (i < 4)                      issue(1'b0, 1'b1);
      else if (i < 4 + FRAME + 30)    issue(1'b1, 1'b1);
      else if (i < 4 + 2*FRAME + 60)  issue(1'b1, (i % 4) == 0);
      else                            issue($urandom_range(0, 299) != 0,
                                            $urandom_range(0, 3) != 0);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: every cycle the DUTs present outputs, compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("curr_x_lat",   32'(x_a),  32'(e.x));
        chk("curr_y_lat",   32'(y_a),  32'(e.y));
        chk("coord_valid_lat", 32'(cv_a), 32'(e.cv));
        chk("line_start_lat",  32'(ls_a), 32'(e.ls));
        chk("frame_start_lat", 32'(fs_a), 32'(e.fs));
        chk("hsync_lat",    32'(hs_a), 32'(e.hs_a));
        chk("vsync_lat",    32'(vs_a), 32'(e.vs_a));
        chk("de_lat",       32'(de_a), 32'(e.de_a));
        chk("pix_rgb_lat",  32'(rgb_a), 32'(e.rgb_a));
        chk("curr_x_dir",   32'(x_b),  32'(e.x));
        chk("curr_y_dir",   32'(y_b),  32'(e.y));
        chk("coord_valid_dir", 32'(cv_b), 32'(e.cv));
        chk("line_start_dir",  32'(ls_b), 32'(e.ls));
        chk("frame_start_dir", 32'(fs_b), 32'(e.fs));
        chk("hsync_dir",    32'(hs_b), 32'(e.hs_b));
        chk("vsync_dir",    32'(vs_b), 32'(e.vs_b));
        chk("de_dir",       32'(de_b), 32'(e.de_b));
        chk("pix_rgb_dir",  32'(rgb_b), 32'(e.rgb_b));
      end
    end
  end

endmodule
`default_nettype wire
